// File: rtl/brk_arb.sv
// brk_arb -- data-break arbiter.
//
// Steals memory cycles from the CPU at instruction boundaries for up to four
// data-break channels. A transfer walks IDLE -> B0 (address) -> BW (wait,
// BW_CYCLES cycles) -> B1 (data) -> B2 (ack). From B2 it chains straight into
// another transfer when a different channel is still requesting.
//
// Configuration macro: BRK_ROUND_ROBIN_EN
//   defined   : rotating priority. The pointer moves to (acked channel + 1) mod 4.
//   undefined : fixed priority. Channel 0 is highest; there is no pointer.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   instr_done  CPU at instruction boundary (one-cycle pulse)
//   brk_req     per-channel break request, level [0:3]
//   brk_write   per-channel direction, 1 = write to memory [0:3]
//   cpu_hold    stalls the CPU major-state sequencer
//   brk_grant   one-hot owner of the memory mux, all-zero = CPU [0:3]
//   mem_we      one-cycle RAM write strobe (B1 of a write transfer)
//   brk_ack     one-cycle completion pulse to the granted channel [0:3]
//   brk_busy    arbiter is outside IDLE
module brk_arb #(
  parameter int BW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_done,
  input  logic [0:3] brk_req,
  input  logic [0:3] brk_write,
  output logic       cpu_hold,
  output logic [0:3] brk_grant,
  output logic       mem_we,
  output logic [0:3] brk_ack,
  output logic       brk_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_BW   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic [0:3] grant_q, grant_d;
  logic       hold_q, hold_d;
  logic       we_q, we_d;
  logic [0:3] ack_q, ack_d;
  logic [1:0] idle_start_s;
  logic [1:0] b2_start_s;
  logic [0:3] others_s;

  // Index of the single set bit of a one-hot channel vector.
  function automatic logic [1:0] onehot_idx(input logic [0:3] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // First requesting channel found when searching upward from 'start' (wrapping).
  function automatic logic [0:3] pick(input logic [0:3] req, input logic [1:0] start);
    logic [0:3] res;
    logic       found;
    logic [1:0] idx;
    res   = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  // Requests that may chain from B2. The just-acked channel is excluded.
  assign others_s = brk_req & ~grant_q;

`ifdef BRK_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // The pointer advances past the channel acknowledged in B2.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_B2) begin
      ptr_d = onehot_idx(grant_q) + 2'd1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign idle_start_s = ptr_q;
  assign b2_start_s   = ptr_d;

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign idle_start_s = 2'd0;
  assign b2_start_s   = 2'd0;
`endif

  // Next-state, winner selection and wait counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (instr_done && (|brk_req)) begin
          state_d = S_B0;
          grant_d = pick(brk_req, idle_start_s);
        end else begin
          grant_d = 4'b0000;
        end
      end
      S_B0: begin
        state_d = S_BW;
        wait_d  = 2'(BW_CYCLES);
      end
      S_BW: begin
        if (wait_q <= 2'd1) begin
          state_d = S_B1;
          wait_d  = 2'd0;
        end else begin
          wait_d  = wait_q - 2'd1;
        end
      end
      S_B1: state_d = S_B2;
      S_B2: begin
        if (|others_s) begin
          state_d = S_B0;
          grant_d = pick(others_s, b2_start_s);
        end else begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = 2'd0;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they are registered
  // and line up with the state they describe.
  always_comb begin
    hold_d = (state_d != S_IDLE);
    we_d   = (state_d == S_B1) && (|(grant_d & brk_write));
    ack_d  = (state_d == S_B2) ? grant_d : 4'b0000;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 2'd0;
      grant_q <= 4'b0000;
      hold_q  <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
    end
  end

  assign cpu_hold  = hold_q;
  assign brk_busy  = hold_q;
  assign brk_grant = grant_q;
  assign mem_we    = we_q;
  assign brk_ack   = ack_q;

endmodule
